// File: rtl/bcd_disp_pkg.sv
// Shared types and segment constants for the 2-digit BCD scan display.
package bcd_disp_pkg;

  typedef enum logic [2:0] {IDLE, SHOW0, GAP0, SHOW1, GAP1} scan_state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_E     = 7'h06;

  // Active-low {g,f,e,d,c,b,a}; element [0] is digit 0.
  localparam logic [9:0][6:0] SEG_TABLE = {
    7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
    7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational digit to active-low 7-segment encoder; 10..15 render as E.
module bcd_to_seg7
  import bcd_disp_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_E;
    if (digit <= 4'd9) seg = SEG_TABLE[digit];
  end

endmodule

// File: rtl/bcd_seg_scan.sv
// Two-digit multiplexed common-anode display scanner with frame-synchronous
// value update and registered outputs aligned to the state register.
module bcd_seg_scan
  import bcd_disp_pkg::*;
#(
  parameter int REFRESH_DIV = 50000,
  parameter int GAP_CYCLES  = 500,
  parameter bit LZ_BLANK    = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       load,
  input  logic [4:0] bcd_in,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic       frame_start,
  output logic       err
);

  localparam int MAX_LIM = (REFRESH_DIV > GAP_CYCLES) ? REFRESH_DIV : GAP_CYCLES;
  localparam int CNT_W   = (MAX_LIM > 1) ? $clog2(MAX_LIM) : 1;
  localparam bit HAS_GAP = (GAP_CYCLES > 0);
  localparam logic [CNT_W-1:0] SHOW_TC = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_TC  = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  scan_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       shadow_q, shadow_d;
  logic [4:0]       disp_q, disp_d;
  logic [6:0]       seg_d;
  logic [1:0]       an_d;
  logic             fs_d, err_d;
  logic             new_frame, invalid;
  logic [6:0]       ones_seg, tens_seg;

  // Encoders look at the value the next cycle will display, so the
  // registered outputs line up with the registered state.
  bcd_to_seg7 u_ones (.digit(disp_d[3:0]),        .seg(ones_seg));
  bcd_to_seg7 u_tens (.digit({3'b000, disp_d[4]}), .seg(tens_seg));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = SHOW0;
      SHOW0:   if (cnt_q == SHOW_TC) state_d = HAS_GAP ? GAP0 : SHOW1;
      GAP0:    if (cnt_q == GAP_TC)  state_d = SHOW1;
      SHOW1:   if (cnt_q == SHOW_TC) state_d = HAS_GAP ? GAP1 : SHOW0;
      GAP1:    if (cnt_q == GAP_TC)  state_d = SHOW0;
      default: state_d = IDLE;
    endcase
    if (!en) state_d = IDLE;

    new_frame = (state_d == SHOW0) && (state_q != SHOW0);
    cnt_d     = ((state_d != state_q) || (state_d == IDLE)) ? '0 : cnt_q + 1'b1;

    // shadow_d already carries a same-cycle load, which gives the bypass.
    shadow_d = load ? bcd_in : shadow_q;
    disp_d   = new_frame ? shadow_d : disp_q;
    invalid  = (disp_d[3:0] > 4'd9);

    seg_d = SEG_BLANK;
    an_d  = 2'b11;
    fs_d  = new_frame;
    err_d = invalid && (state_d != IDLE);
    case (state_d)
      SHOW0: begin
        an_d  = 2'b10;
        seg_d = ones_seg;
      end
      SHOW1: begin
        if (invalid) begin
          an_d  = 2'b01;
          seg_d = SEG_E;
        end else if (!(LZ_BLANK && !disp_d[4])) begin
          an_d  = 2'b01;
          seg_d = tens_seg;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      shadow_q    <= 5'b0;
      disp_q      <= 5'b0;
      seg         <= SEG_BLANK;
      an          <= 2'b11;
      frame_start <= 1'b0;
      err         <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shadow_q    <= shadow_d;
      disp_q      <= disp_d;
      seg         <= seg_d;
      an          <= an_d;
      frame_start <= fs_d;
      err         <= err_d;
    end
  end

endmodule

// File: tb/tb_bcd_seg_scan.sv
// Randomized + directed bench for bcd_seg_scan, checked against a frame-position model.
module tb_bcd_seg_scan;

  localparam int NI = 3;

  logic       clk = 1'b0;
  logic       rst_n, en, load;
  logic [4:0] bcd_in;
  logic [6:0] seg_o [NI];
  logic [1:0] an_o  [NI];
  logic       fs_o  [NI];
  logic       err_o [NI];

  int n_cmp = 0;
  int n_bad = 0;

  int pr [NI] = '{4, 4, 3};
  int pg [NI] = '{1, 1, 0};
  bit pl [NI] = '{1'b1, 1'b0, 1'b1};

  bit         m_act  [NI];
  int         m_pos  [NI];
  logic [4:0] m_sh   [NI];
  logic [4:0] m_disp [NI];

  always #5 clk = ~clk;

  bcd_seg_scan #(.REFRESH_DIV(4), .GAP_CYCLES(1), .LZ_BLANK(1'b1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load), .bcd_in(bcd_in),
    .seg(seg_o[0]), .an(an_o[0]), .frame_start(fs_o[0]), .err(err_o[0]));
  bcd_seg_scan #(.REFRESH_DIV(4), .GAP_CYCLES(1), .LZ_BLANK(1'b0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load), .bcd_in(bcd_in),
    .seg(seg_o[1]), .an(an_o[1]), .frame_start(fs_o[1]), .err(err_o[1]));
  bcd_seg_scan #(.REFRESH_DIV(3), .GAP_CYCLES(0), .LZ_BLANK(1'b1)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load), .bcd_in(bcd_in),
    .seg(seg_o[2]), .an(an_o[2]), .frame_start(fs_o[2]), .err(err_o[2]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s obs=%0h exp=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [6:0] enc(input logic [3:0] d);
    case (d)
      4'd0: return 7'h40; 4'd1: return 7'h79; 4'd2: return 7'h24; 4'd3: return 7'h30;
      4'd4: return 7'h19; 4'd5: return 7'h12; 4'd6: return 7'h02; 4'd7: return 7'h78;
      4'd8: return 7'h00; 4'd9: return 7'h10;
      default: return 7'h06;
    endcase
  endfunction

  // Model: position within the frame; frame start is position 0.
  task automatic model_edge(input bit r, input bit e, input bit l, input logic [4:0] b);
    for (int i = 0; i < NI; i++) begin
      logic [4:0] nsh;
      bit enter;
      if (!r) begin
        m_act[i] = 0; m_pos[i] = 0; m_sh[i] = 5'd0; m_disp[i] = 5'd0;
      end else begin
        nsh   = l ? b : m_sh[i];
        enter = 0;
        if (!e) m_act[i] = 0;
        else if (!m_act[i]) begin
          m_act[i] = 1; m_pos[i] = 0; enter = 1;
        end else begin
          m_pos[i] = (m_pos[i] + 1) % (2 * (pr[i] + pg[i]));
          enter    = (m_pos[i] == 0);
        end
        if (enter) m_disp[i] = nsh;
        m_sh[i] = nsh;
      end
    end
  endtask

  task automatic expect_out(input int i, output logic [6:0] s, output logic [1:0] a,
                            output logic f, output logic er);
    int r, g;
    logic [3:0] ones;
    bit bad;
    r = pr[i]; g = pg[i];
    ones = m_disp[i][3:0];
    bad  = (ones > 4'd9);
    s = 7'h7F; a = 2'b11; f = 1'b0; er = 1'b0;
    if (m_act[i]) begin
      f  = (m_pos[i] == 0);
      er = bad;
      if (m_pos[i] < r) begin
        a = 2'b10; s = enc(ones);
      end else if (m_pos[i] >= r + g && m_pos[i] < 2 * r + g) begin
        if (bad) begin
          a = 2'b01; s = 7'h06;
        end else if (!(pl[i] && !m_disp[i][4])) begin
          a = 2'b01; s = enc({3'b000, m_disp[i][4]});
        end
      end
    end
  endtask

  task automatic cyc(input bit r, input bit e, input bit l, input logic [4:0] b);
    logic [6:0] s;
    logic [1:0] a;
    logic f, er;
    rst_n = r; en = e; load = l; bcd_in = b;
    @(posedge clk);
    model_edge(r, e, l, b);
    #1;
    for (int i = 0; i < NI; i++) begin
      expect_out(i, s, a, f, er);
      check($sformatf("seg[%0d]", i), seg_o[i], s);
      check($sformatf("an[%0d]", i), an_o[i], a);
      check($sformatf("frame_start[%0d]", i), fs_o[i], f);
      check($sformatf("err[%0d]", i), err_o[i], er);
      check($sformatf("an_not_00[%0d]", i), an_o[i] != 2'b00, 1);
    end
  endtask

  // Idle-free run until instance 0 sits at a given frame position (bounded).
  task automatic run_to(input int target);
    for (int k = 0; k < 24 && !(m_act[0] && m_pos[0] == target); k++) cyc(1, 1, 0, 5'd0);
    check("run_to_reached", (m_act[0] && m_pos[0] == target), 1);
  endtask

  initial begin
    rst_n = 0; en = 0; load = 0; bcd_in = 5'd0;
    for (int i = 0; i < NI; i++) begin
      m_act[i] = 0; m_pos[i] = 0; m_sh[i] = 5'd0; m_disp[i] = 5'd0;
    end
    cyc(0, 0, 0, 5'd0);
    cyc(0, 0, 0, 5'd0);

    // 13 loaded in IDLE, then scan two frames
    cyc(1, 0, 1, 5'b1_0011);
    for (int k = 0; k < 21; k++) cyc(1, 1, 0, 5'd0);

    // 7: leading-zero blank on tens
    cyc(1, 1, 1, 5'b0_0111);
    for (int k = 0; k < 22; k++) cyc(1, 1, 0, 5'd0);

    // invalid value loaded mid-SHOW1, then a valid one
    run_to(6);
    cyc(1, 1, 1, 5'b0_1010);
    for (int k = 0; k < 24; k++) cyc(1, 1, 0, 5'd0);
    cyc(1, 1, 1, 5'b1_0010);
    for (int k = 0; k < 20; k++) cyc(1, 1, 0, 5'd0);

    // load on the edge that enters SHOW0 (bypass)
    run_to(9);
    cyc(1, 1, 1, 5'b1_0101);
    for (int k = 0; k < 10; k++) cyc(1, 1, 0, 5'd0);

    // en dropped during GAP0, then re-enabled
    run_to(4);
    cyc(1, 0, 0, 5'd0);
    cyc(1, 0, 0, 5'd0);
    for (int k = 0; k < 12; k++) cyc(1, 1, 0, 5'd0);

    // reset during SHOW1
    run_to(6);
    cyc(0, 1, 0, 5'd0);
    for (int k = 0; k < 12; k++) cyc(1, 1, 0, 5'd0);

    // random traffic
    for (int k = 0; k < 600; k++) begin
      bit r, e, l;
      r = ($urandom_range(0, 99) != 0);
      e = ($urandom_range(0, 99) > 3);
      l = ($urandom_range(0, 99) < 20);
      cyc(r, e, l, 5'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
